// File: rtl/mac_array_seq_pkg.sv
// Shared types and constants for the MAC-array sequencer.
package mac_array_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GAP   = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DRAIN = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  localparam int COL_ID_W = 3;
  localparam int COL_MAX  = 8;
  // Column i holds id i: {7,6,5,4,3,2,1,0}.
  localparam logic [COL_ID_W*COL_MAX-1:0] COL_ID_DEFAULT = 24'hFAC688;

endpackage

// File: rtl/mac_array_seq_addr_cnt.sv
// Address counter with clear (priority), enable-increment and hold; wraps modulo 2^W.
// Registered output, updates one cycle after clr/en.
module seq_addr_cnt
  import mac_array_seq_pkg::*;
#(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] addr
);

  logic [W-1:0] addr_q, addr_d;

  always_comb begin
    addr_d = addr_q;
    if (clr) begin
      addr_d = '0;
    end else if (en) begin
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/mac_array_seq.sv
// Sequencer for the weight-stationary MAC array: load, gap, execute, drain.
// done = col+N+3+D cycles after start; stall pauses EXEC reads only.
module mac_array_seq
  import mac_array_seq_pkg::*;
#(
  parameter int col = 8,
  parameter int pr  = 8,
  parameter int aw  = 6
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [aw-1:0]           n_act,
  input  logic                    stall,
  input  logic                    cfg_we,
  input  logic [COL_ID_W*col-1:0] cfg_data,
  input  logic                    fifo_wr_last,
  output logic [1:0]              inst,
  output logic                    w_rd_en,
  output logic [aw-1:0]           w_addr,
  output logic                    x_rd_en,
  output logic [aw-1:0]           x_addr,
  output logic [COL_ID_W*col-1:0] col_ids,
  output logic                    busy,
  output logic                    done
);

  if (col < 1 || col > COL_MAX || pr < 1) begin : g_bad_cfg
    $error("mac_array_seq: col must be 1..8 and pr must be >= 1");
  end

  localparam logic [COL_ID_W*col-1:0] COL_ID_RST = COL_ID_DEFAULT[COL_ID_W*col-1:0];
  localparam logic [aw-1:0]           LOAD_LAST  = aw'(col - 1);

  state_e                  state_q, state_d;
  logic [aw-1:0]           n_act_q, n_act_d;
  logic [aw-1:0]           k_cnt_q, k_cnt_d;
  logic [aw-1:0]           wr_cnt_q, wr_cnt_d;
  logic [1:0]              inst_q, inst_d;
  logic [COL_ID_W*col-1:0] col_ids_q, col_ids_d;
  logic                    start_acc;
  logic                    w_en;
  logic                    x_en;
  logic                    counting;

  always_comb begin
    state_d   = state_q;
    n_act_d   = n_act_q;
    k_cnt_d   = k_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    col_ids_d = col_ids_q;
    start_acc = 1'b0;
    w_en      = 1'b0;
    x_en      = 1'b0;
    counting  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cfg_we) begin
          col_ids_d = cfg_data;
        end
        if (start) begin
          start_acc = 1'b1;
          n_act_d   = n_act;
          k_cnt_d   = '0;
          wr_cnt_d  = '0;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        w_en     = 1'b1;
        counting = 1'b1;
        if (w_addr == LOAD_LAST) begin
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        counting = 1'b1;
        state_d  = (n_act_q != '0) ? ST_EXEC : ST_DONE;
      end
      ST_EXEC: begin
        counting = 1'b1;
        if (!stall) begin
          x_en    = 1'b1;
          k_cnt_d = k_cnt_q + 1'b1;
          if (({1'b0, k_cnt_q} + 1'b1) == {1'b0, n_act_q}) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        counting = 1'b1;
        // The registered inst must also be idle so the last execute beat has left.
        if (wr_cnt_q == n_act_q && inst_q == INST_IDLE) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (counting && fifo_wr_last && wr_cnt_q != '1) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end

    inst_d = {x_en, w_en};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      n_act_q   <= '0;
      k_cnt_q   <= '0;
      wr_cnt_q  <= '0;
      inst_q    <= INST_IDLE;
      col_ids_q <= COL_ID_RST;
    end else begin
      state_q   <= state_d;
      n_act_q   <= n_act_d;
      k_cnt_q   <= k_cnt_d;
      wr_cnt_q  <= wr_cnt_d;
      inst_q    <= inst_d;
      col_ids_q <= col_ids_d;
    end
  end

  seq_addr_cnt #(.W(aw)) u_w_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_acc),
    .en    (w_en),
    .addr  (w_addr)
  );

  seq_addr_cnt #(.W(aw)) u_x_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start_acc),
    .en    (x_en),
    .addr  (x_addr)
  );

  assign inst    = inst_q;
  assign w_rd_en = w_en;
  assign x_rd_en = x_en;
  assign col_ids = col_ids_q;
  assign busy    = (state_q != ST_IDLE);
  assign done    = (state_q == ST_DONE);

endmodule

// File: tb/tb_mac_array_seq.sv
// Scoreboard bench for mac_array_seq: runs push expected reads/insts/done cycles,
// a negedge monitor pops and compares; a second aw=3 instance covers address wrap.
module tb_mac_array_seq;

  localparam int COL = 8;
  localparam int AW  = 6;
  localparam logic [23:0] DEF_IDS = 24'hFAC688;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [AW-1:0]   n_act = '0;
  logic            stall = 1'b0;
  logic            cfg_we = 1'b0;
  logic [3*COL-1:0] cfg_data = '0;
  logic            fifo_wr_last;
  logic [1:0]      inst;
  logic            w_rd_en, x_rd_en, busy, done;
  logic [AW-1:0]   w_addr, x_addr;
  logic [3*COL-1:0] col_ids;

  logic            start3 = 1'b0;
  logic [2:0]      n_act3 = '0;
  logic            fwl3;
  logic [1:0]      inst3;
  logic            w_rd_en3, x_rd_en3, busy3, done3;
  logic [2:0]      w_addr3, x_addr3;
  logic [3*COL-1:0] col_ids3;

  mac_array_seq #(.col(COL), .pr(8), .aw(AW)) u_dut (
    .clk(clk), .reset(reset), .start(start), .n_act(n_act), .stall(stall),
    .cfg_we(cfg_we), .cfg_data(cfg_data), .fifo_wr_last(fifo_wr_last),
    .inst(inst), .w_rd_en(w_rd_en), .w_addr(w_addr), .x_rd_en(x_rd_en),
    .x_addr(x_addr), .col_ids(col_ids), .busy(busy), .done(done)
  );

  mac_array_seq #(.col(COL), .pr(8), .aw(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .n_act(n_act3), .stall(1'b0),
    .cfg_we(1'b0), .cfg_data(24'h0), .fifo_wr_last(fwl3),
    .inst(inst3), .w_rd_en(w_rd_en3), .w_addr(w_addr3), .x_rd_en(x_rd_en3),
    .x_addr(x_addr3), .col_ids(col_ids3), .busy(busy3), .done(done3)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Array model: last column writes its psum one cycle after each execute beat.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fifo_wr_last <= 1'b0;
      fwl3         <= 1'b0;
    end else begin
      fifo_wr_last <= (inst == 2'b10);
      fwl3         <= (inst3 == 2'b10);
    end
  end

  logic [AW-1:0] exp_w[$];
  logic [AW-1:0] exp_x[$];
  logic [1:0]    exp_inst[$];
  int            exp_done[$];
  logic [2:0]    exp_x3[$];
  int            n_checks = 0;
  int            n_err = 0;
  int            n_done3 = 0;
  logic          prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (w_rd_en) begin
        if (exp_w.size() == 0) check("w_rd_unexpected", 32'(w_addr), 32'hFFFF_FFFF);
        else check("w_addr", 32'(w_addr), 32'(exp_w.pop_front()));
      end
      if (x_rd_en) begin
        if (exp_x.size() == 0) check("x_rd_unexpected", 32'(x_addr), 32'hFFFF_FFFF);
        else check("x_addr", 32'(x_addr), 32'(exp_x.pop_front()));
      end
      if (inst != 2'b00) begin
        if (exp_inst.size() == 0) check("inst_unexpected", 32'(inst), 32'h0);
        else check("inst", 32'(inst), 32'(exp_inst.pop_front()));
      end
      if (done) begin
        if (exp_done.size() == 0) check("done_unexpected", cyc, 32'hFFFF_FFFF);
        else check("done_cycle", cyc, exp_done.pop_front());
      end
      if (prev_done) check("busy_after_done", 32'(busy), 32'h0);
      prev_done <= done;
      if (x_rd_en3) begin
        if (exp_x3.size() == 0) check("x3_rd_unexpected", 32'(x_addr3), 32'hFFFF_FFFF);
        else check("x3_addr", 32'(x_addr3), 32'(exp_x3.pop_front()));
      end
      if (done3) n_done3 <= n_done3 + 1;
    end
  end

  task automatic run(input int n, input int stall_at, input int inj_at, input int rst_at,
                     input logic cfg_en, input logic [23:0] cfg_val);
    int t0;
    int i;
    bit aborted;
    aborted = 1'b0;
    @(posedge clk); #1;
    t0 = cyc;
    for (int k = 0; k < COL; k++) begin
      exp_w.push_back(AW'(k));
      exp_inst.push_back(2'b01);
    end
    for (int k = 0; k < n; k++) begin
      exp_x.push_back(AW'(k));
      exp_inst.push_back(2'b10);
    end
    exp_done.push_back(n == 0 ? t0 + 10 : t0 + 13 + n + (stall_at >= 0 ? 3 : 0));
    start = 1'b1; n_act = AW'(n); cfg_we = cfg_en; cfg_data = cfg_val;
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    i = 1;
    while (busy && i < 500 && !aborted) begin
      if (stall_at >= 0 && cyc == t0 + stall_at) stall = 1'b1;
      if (stall_at >= 0 && cyc == t0 + stall_at + 3) stall = 1'b0;
      if (cyc == t0 + inj_at) begin
        start = 1'b1; cfg_we = 1'b1; cfg_data = '0; n_act = '0;
      end else begin
        start = 1'b0; cfg_we = 1'b0;
      end
      if (cyc == t0 + rst_at) begin
        #1 reset = 1'b0;
        #1;
        check("midrst_outs", 32'({inst, w_rd_en, w_addr, x_rd_en, x_addr, busy, done}), 32'h0);
        check("midrst_col_ids", 32'(col_ids), 32'(DEF_IDS));
        exp_w.delete(); exp_x.delete(); exp_inst.delete(); exp_done.delete();
        @(posedge clk); #1 reset = 1'b1;
        aborted = 1'b1;
      end else begin
        @(posedge clk); #1;
        i++;
      end
    end
    if (!aborted) check("run_timeout", 32'(busy), 32'h0);
    stall = 1'b0; start = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic run3(input int n);
    int i;
    @(posedge clk); #1;
    for (int k = 0; k < n; k++) exp_x3.push_back(3'(k));
    start3 = 1'b1; n_act3 = 3'(n);
    @(posedge clk); #1;
    start3 = 1'b0;
    i = 1;
    while (busy3 && i < 500) begin
      @(posedge clk); #1;
      i++;
    end
    check("run3_timeout", 32'(busy3), 32'h0);
    check("x3_left", exp_x3.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    #1 reset = 1'b0;
    #2;
    check("rst_outs", 32'({inst, w_rd_en, w_addr, x_rd_en, x_addr, busy, done}), 32'h0);
    check("rst_col_ids", 32'(col_ids), 32'(DEF_IDS));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    run(4, -1, -1, -1, 1'b0, 24'h0);
    run(0, -1, -1, -1, 1'b0, 24'h0);
    run(6, 12, -1, -1, 1'b0, 24'h0);
    run(3, -1, 11, -1, 1'b0, 24'h0);
    check("ignored_cfg_col_ids", 32'(col_ids), 32'(DEF_IDS));
    run(5, -1, -1, 12, 1'b0, 24'h0);
    run(2, -1, -1, -1, 1'b0, 24'h0);
    run(1, -1, -1, -1, 1'b1, 24'h123456);
    check("cfg_with_start_col_ids", 32'(col_ids), 32'h0012_3456);

    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_data = '0;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    check("idle_cfg_zero", 32'(col_ids), 32'h0);

    run3(7);
    run3(7);
    check("w3_wrapped", 32'({w_rd_en3, w_addr3}), 32'h0);
    check("dut3_col_ids", 32'(col_ids3), 32'(DEF_IDS));

    repeat (3) @(posedge clk);
    #1;
    check("done3_count", n_done3, 2);
    check("w_left", exp_w.size(), 0);
    check("x_left", exp_x.size(), 0);
    check("inst_left", exp_inst.size(), 0);
    check("done_left", exp_done.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
